wash_sequencer: RTL and testbench

- Sequences the wash datapath (water valve, drum motor, drain pump) through the fill/wash/rinse/spin phases of the selected program.
- Runs only while the top-level controller is in its run state: `run`=1 in run, 0 in pause/error/sleep.
- Reports per-phase and total remaining time for the display.
- Asserts `hadFinish` back to the top-level controller when the program completes.

---
 rtl/wash_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Wash program sequencer: steps the valve, motor and drain pump through the fill/wash/rinse/spin phases.
// Optional level sensor early FILL exit is built when FILL_SENSOR_EN is defined.
module wash_sequencer #(
  parameter int unsigned FILL_TIME   = 1,
  parameter int unsigned WASH_TIME   = 9,
  parameter int unsigned RINSE_TIME  = 3,
  parameter int unsigned RINSE_LOOPS = 2,
  parameter int unsigned DRAIN_TIME  = 1,
  parameter int unsigned SPIN_TIME   = 3,
  parameter int unsigned TW          = 8
) (
  input  logic          cp,
  input  logic          reset,
  input  logic          tick,
  input  logic          run,
  input  logic          start,
  input  logic          clear,
  input  logic [2:0]    mode,
`ifdef FILL_SENSOR_EN
  input  logic          levelFull,
`endif
  output logic [2:0]    phase,
  output logic [TW-1:0] phaseRemain,
  output logic [TW-1:0] totalRemain,
  output logic [1:0]    rinseLeft,
  output logic          valve,
  output logic          motor,
  output logic          motorFast,
  output logic          drain,
  output logic          hadFinish
);

  localparam int unsigned WASH_SUM  = FILL_TIME + WASH_TIME + DRAIN_TIME;
  localparam int unsigned RINSE_SUM = RINSE_LOOPS * (FILL_TIME + RINSE_TIME + DRAIN_TIME);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_RINSE = 3'd4,
    PH_SPIN  = 3'd5,
    PH_DONE  = 3'd6
  } phase_e;

  phase_e          phase_q, phase_d;
  logic            seg_rinse_q, seg_rinse_d;   // FILL/DRAIN belong to a rinse loop
  logic [1:0]      sel_q, sel_d;               // latched {rinse, spin} selection
  logic [1:0]      rleft_q, rleft_d;
  logic [TW-1:0]   prem_q, prem_d;
  logic [TW-1:0]   trem_q, trem_d;

  logic [2:0]      mode_eff_c;
  logic            active_c;
  logic            count_c;
  logic            expire_c;
  logic            fill_full_c;
  logic            can_start_c;
  phase_e          adv_phase_c;
  logic            adv_rinse_c;
  logic [1:0]      adv_rleft_c;
  logic [1:0]      rleft_dec_c;
  logic [TW-1:0]   start_total_c;
  phase_e          start_phase_c;
  logic            start_rinse_c;

  function automatic logic [TW-1:0] phase_dur(input phase_e p);
    case (p)
      PH_FILL:  phase_dur = TW'(FILL_TIME);
      PH_WASH:  phase_dur = TW'(WASH_TIME);
      PH_DRAIN: phase_dur = TW'(DRAIN_TIME);
      PH_RINSE: phase_dur = TW'(RINSE_TIME);
      PH_SPIN:  phase_dur = TW'(SPIN_TIME);
      default:  phase_dur = '0;
    endcase
  endfunction

  assign mode_eff_c  = (mode == 3'b000) ? 3'b111 : mode;
  assign active_c    = (phase_q != PH_IDLE) && (phase_q != PH_DONE);
  assign count_c     = tick && run && active_c;
  assign expire_c    = count_c && (prem_q <= TW'(1));
  assign can_start_c = (phase_q == PH_IDLE) || (phase_q == PH_DONE);
  assign rleft_dec_c = (rleft_q != 2'd0) ? rleft_q - 2'd1 : 2'd0;

`ifdef FILL_SENSOR_EN
  assign fill_full_c = (phase_q == PH_FILL) && run && levelFull;
`else
  assign fill_full_c = 1'b0;
`endif

  // Program load values for an accepted start
  always_comb begin
    start_total_c = '0;
    start_phase_c = PH_SPIN;
    start_rinse_c = 1'b0;
    if (mode_eff_c[2]) start_total_c = start_total_c + TW'(WASH_SUM);
    if (mode_eff_c[1]) start_total_c = start_total_c + TW'(RINSE_SUM);
    if (mode_eff_c[0]) start_total_c = start_total_c + TW'(SPIN_TIME);
    if (mode_eff_c[2]) begin
      start_phase_c = PH_FILL;
    end else if (mode_eff_c[1]) begin
      start_phase_c = PH_FILL;
      start_rinse_c = 1'b1;
    end
  end

  // Phase that follows the current one when it runs out
  always_comb begin
    adv_phase_c = PH_DONE;
    adv_rinse_c = seg_rinse_q;
    adv_rleft_c = rleft_q;
    case (phase_q)
      PH_FILL:  adv_phase_c = seg_rinse_q ? PH_RINSE : PH_WASH;
      PH_WASH: begin
        adv_phase_c = PH_DRAIN;
        adv_rinse_c = 1'b0;
      end
      PH_RINSE: begin
        adv_phase_c = PH_DRAIN;
        adv_rinse_c = 1'b1;
      end
      PH_DRAIN: begin
        if (seg_rinse_q) begin
          adv_rleft_c = rleft_dec_c;
          if (rleft_dec_c != 2'd0) begin
            adv_phase_c = PH_FILL;
          end else begin
            adv_phase_c = sel_q[0] ? PH_SPIN : PH_DONE;
            adv_rinse_c = 1'b0;
          end
        end else if (sel_q[1]) begin
          adv_phase_c = PH_FILL;
          adv_rinse_c = 1'b1;
        end else begin
          adv_phase_c = sel_q[0] ? PH_SPIN : PH_DONE;
        end
      end
      PH_SPIN: begin
        adv_phase_c = PH_DONE;
        adv_rinse_c = 1'b0;
      end
      default: adv_phase_c = phase_q;
    endcase
  end

  // Next-state: clear > start > level/tick advance > counted tick
  always_comb begin
    phase_d     = phase_q;
    seg_rinse_d = seg_rinse_q;
    sel_d       = sel_q;
    rleft_d     = rleft_q;
    prem_d      = prem_q;
    trem_d      = trem_q;
    if (clear) begin
      phase_d     = PH_IDLE;
      seg_rinse_d = 1'b0;
      rleft_d     = 2'd0;
      prem_d      = '0;
      trem_d      = '0;
    end else if (start && can_start_c) begin
      phase_d     = start_phase_c;
      seg_rinse_d = start_rinse_c;
      sel_d       = mode_eff_c[1:0];
      rleft_d     = mode_eff_c[1] ? 2'(RINSE_LOOPS) : 2'd0;
      prem_d      = phase_dur(start_phase_c);
      trem_d      = start_total_c;
    end else if (fill_full_c || expire_c) begin
      phase_d     = adv_phase_c;
      seg_rinse_d = adv_rinse_c;
      rleft_d     = adv_rleft_c;
      prem_d      = phase_dur(adv_phase_c);
      if (fill_full_c) begin
        trem_d = (trem_q > prem_q) ? trem_q - prem_q : '0;
      end else begin
        trem_d = (trem_q != '0) ? trem_q - TW'(1) : '0;
      end
      if (adv_phase_c == PH_DONE) trem_d = '0;
    end else if (count_c) begin
      prem_d = (prem_q != '0) ? prem_q - TW'(1) : '0;
      trem_d = (trem_q != '0) ? trem_q - TW'(1) : '0;
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      phase_q     <= PH_IDLE;
      seg_rinse_q <= 1'b0;
      sel_q       <= 2'b00;
      rleft_q     <= 2'd0;
      prem_q      <= '0;
      trem_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      seg_rinse_q <= seg_rinse_d;
      sel_q       <= sel_d;
      rleft_q     <= rleft_d;
      prem_q      <= prem_d;
      trem_q      <= trem_d;
    end
  end

  // Actuators follow the registered phase but drop immediately on pause
  assign phase       = phase_q;
  assign phaseRemain = prem_q;
  assign totalRemain = trem_q;
  assign rinseLeft   = rleft_q;
  assign valve       = run && (phase_q == PH_FILL);
  assign motor       = run && ((phase_q == PH_WASH) || (phase_q == PH_RINSE) || (phase_q == PH_SPIN));
  assign motorFast   = run && (phase_q == PH_SPIN);
  assign drain       = run && ((phase_q == PH_DRAIN) || (phase_q == PH_SPIN));
  assign hadFinish   = (phase_q == PH_DONE);

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer; compares every cycle against a phase-list model.
module tb_wash_sequencer;

`ifdef FILL_SENSOR_EN
  localparam int F       = 5;
  localparam int TOT_ALL = 36;
`else
  localparam int F       = 1;
  localparam int TOT_ALL = 24;
`endif

  logic       cp = 1'b0;
  logic       reset, tick, run, start, clear;
  logic [2:0] mode;
`ifdef FILL_SENSOR_EN
  logic       levelFull = 1'b0;
`endif
  logic [2:0] phase;
  logic [7:0] phaseRemain, totalRemain;
  logic [1:0] rinseLeft;
  logic       valve, motor, motorFast, drain, hadFinish;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  wash_sequencer #(
    .FILL_TIME(F), .WASH_TIME(9), .RINSE_TIME(3), .RINSE_LOOPS(2),
    .DRAIN_TIME(1), .SPIN_TIME(3), .TW(8)
  ) dut (
    .cp(cp), .reset(reset), .tick(tick), .run(run), .start(start), .clear(clear), .mode(mode),
`ifdef FILL_SENSOR_EN
    .levelFull(levelFull),
`endif
    .phase(phase), .phaseRemain(phaseRemain), .totalRemain(totalRemain), .rinseLeft(rinseLeft),
    .valve(valve), .motor(motor), .motorFast(motorFast), .drain(drain), .hadFinish(hadFinish)
  );

  always #5 cp = ~cp;

  // Model: the program is a list of {phase, ticks left} still to run
  typedef struct { int ph; int rem; bit rinse_drain; } seg_t;
  seg_t mq[$];
  bit   m_active = 1'b0;

  task automatic push_seg(input int ph, input int rem, input bit rd);
    seg_t s;
    s.ph = ph; s.rem = rem; s.rinse_drain = rd;
    mq.push_back(s);
  endtask

  task automatic model_step();
    logic [2:0] md;
    if (reset || clear) begin
      m_active = 1'b0;
      mq.delete();
    end else if (start && (!m_active || mq.size() == 0)) begin
      md = (mode == 3'b000) ? 3'b111 : mode;
      mq.delete();
      m_active = 1'b1;
      if (md[2]) begin
        push_seg(1, F, 1'b0); push_seg(2, 9, 1'b0); push_seg(3, 1, 1'b0);
      end
      if (md[1]) for (int i = 0; i < 2; i++) begin
        push_seg(1, F, 1'b0); push_seg(4, 3, 1'b0); push_seg(3, 1, 1'b1);
      end
      if (md[0]) push_seg(5, 3, 1'b0);
    end else if (m_active && mq.size() > 0) begin
`ifdef FILL_SENSOR_EN
      if (mq[0].ph == 1 && run && levelFull) void'(mq.pop_front());
      else
`endif
      if (tick && run) begin
        mq[0].rem = mq[0].rem - 1;
        if (mq[0].rem == 0) void'(mq.pop_front());
      end
    end
  endtask

  function automatic int m_phase();
    if (!m_active) return 0;
    if (mq.size() == 0) return 6;
    return mq[0].ph;
  endfunction

  function automatic int m_prem();
    return (m_active && mq.size() > 0) ? mq[0].rem : 0;
  endfunction

  function automatic int m_total();
    int s = 0;
    foreach (mq[i]) s += mq[i].rem;
    return s;
  endfunction

  function automatic int m_rleft();
    int n = 0;
    foreach (mq[i]) if (mq[i].rinse_drain) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge cp) begin
    if (chk_en) begin
      int p;
      p = m_phase();
      chk("phase", 32'(phase), p);
      chk("phaseRemain", 32'(phaseRemain), m_prem());
      chk("totalRemain", 32'(totalRemain), m_total());
      chk("rinseLeft", 32'(rinseLeft), m_rleft());
      chk("valve", 32'(valve), int'(run && p == 1));
      chk("motor", 32'(motor), int'(run && (p == 2 || p == 4 || p == 5)));
      chk("motorFast", 32'(motorFast), int'(run && p == 5));
      chk("drain", 32'(drain), int'(run && (p == 3 || p == 5)));
      chk("hadFinish", 32'(hadFinish), int'(p == 6));
    end
  end

  task automatic cyc(input bit tk, input bit rn, input bit st, input bit cl,
                     input logic [2:0] md, input bit rs);
    tick = tk; run = rn; start = st; clear = cl; mode = md; reset = rs;
    @(posedge cp);
    model_step();
    #2;
  endtask

  task automatic ticks(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      if (gap) cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    end
  endtask

  initial begin
    tick = 0; run = 0; start = 0; clear = 0; mode = 3'b000; reset = 1;
    cyc(0, 0, 0, 0, 3'b000, 1);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 3'b000, 1);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_total", 32'(totalRemain), 0);

    // Full default program
    cyc(0, 1, 1, 0, 3'b000, 0);
    chk("start_phase", 32'(phase), 1);
    chk("start_total", 32'(totalRemain), TOT_ALL);
    chk("start_rinseLeft", 32'(rinseLeft), 2);
    chk("start_valve", 32'(valve), 1);
    ticks(TOT_ALL, 1'b1);
    chk("end_phase", 32'(phase), 6);
    chk("end_hadFinish", 32'(hadFinish), 1);
    chk("end_total", 32'(totalRemain), 0);
    chk("end_motor", 32'(motor), 0);

    // Spin only
    cyc(0, 1, 1, 0, 3'b001, 0);
    chk("spin_phase", 32'(phase), 5);
    chk("spin_prem3", 32'(phaseRemain), 3);
    chk("spin_motorFast", 32'(motorFast), 1);
    chk("spin_drain", 32'(drain), 1);
    ticks(1, 1'b0);
    chk("spin_prem2", 32'(phaseRemain), 2);
    ticks(2, 1'b0);
    chk("spin_done", 32'(phase), 6);

    // Pause during WASH
    cyc(0, 1, 1, 0, 3'b000, 0);
    ticks(F + 4, 1'b0);
    chk("wash_prem5", 32'(phaseRemain), 5);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 3'b000, 0);
    chk("pause_prem", 32'(phaseRemain), 5);
    chk("pause_motor", 32'(motor), 0);
    cyc(0, 1, 0, 0, 3'b000, 0);
    chk("resume_motor", 32'(motor), 1);
    ticks(1, 1'b0);
    chk("resume_prem", 32'(phaseRemain), 4);

    // Start while running is ignored
    cyc(0, 1, 1, 0, 3'b001, 0);
    chk("busy_start_phase", 32'(phase), 2);
    chk("busy_start_total", 32'(totalRemain), TOT_ALL - F - 5);

    // Clear, then start with a coincident tick
    cyc(0, 1, 0, 1, 3'b000, 0);
    chk("clear_phase", 32'(phase), 0);
    cyc(1, 1, 1, 0, 3'b000, 0);
    chk("start_tick_total", 32'(totalRemain), TOT_ALL);
    chk("start_tick_prem", 32'(phaseRemain), F);

    // Clear during the second rinse loop
    ticks(3 * F + 14, 1'b0);
    chk("rinse2_phase", 32'(phase), 4);
    chk("rinse2_left", 32'(rinseLeft), 1);
    cyc(0, 1, 0, 1, 3'b000, 0);
    chk("rinse_clear_phase", 32'(phase), 0);
    chk("rinse_clear_left", 32'(rinseLeft), 0);
    chk("rinse_clear_fin", 32'(hadFinish), 0);

    // Reset mid-spin
    cyc(0, 1, 1, 0, 3'b000, 0);
    ticks(3 * F + 19, 1'b0);
    chk("midspin_phase", 32'(phase), 5);
    chk("midspin_prem", 32'(phaseRemain), 2);
    cyc(0, 1, 0, 0, 3'b000, 1);
    chk("spin_rst_phase", 32'(phase), 0);
    chk("spin_rst_motor", 32'(motor), 0);
    chk("spin_rst_total", 32'(totalRemain), 0);

`ifdef FILL_SENSOR_EN
    // Level sensor ends FILL early
    cyc(0, 1, 1, 0, 3'b000, 0);
    ticks(2, 1'b0);
    chk("lvl_prem", 32'(phaseRemain), 3);
    levelFull = 1'b1;
    cyc(0, 1, 0, 0, 3'b000, 0);
    levelFull = 1'b0;
    chk("lvl_phase", 32'(phase), 2);
    chk("lvl_total", 32'(totalRemain), 31);
`endif

    cyc(0, 1, 0, 0, 3'b000, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
